io_port_controller: RTL and testbench

- Peripheral at the far end of the processor's I/O interface: it drives the processor's in_port and interrupt, and consumes out_port.
- The inbound path buffers words from an external source in a FIFO. The head word is presented on in_port, and an interrupt pulse requests service from the processor.
- The outbound path captures words the processor writes to out_port into a FIFO. An external sink drains that FIFO with a valid/ready handshake.

---
 rtl/io_port_controller_pkg.sv | 22 ++
 rtl/io_port_controller_sync_fifo.sv | 68 ++++++
 rtl/io_port_controller.sv | 117 +++++++++++
 tb/tb_io_port_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_controller_pkg.sv
// Shared definitions for the I/O port controller: default word width,
// interrupt FSM state encoding and a constant-evaluable clog2 helper.
package io_port_controller_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_PULSE = 2'd1,
        IRQ_HOLD  = 2'd2
    } irq_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_port_controller_sync_fifo.sv
// Synchronous FIFO with registered storage. The head reads as 0 when empty,
// and a push into a full FIFO is taken only when a pop frees the slot in the same cycle.
module sync_fifo
    import io_port_controller_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/io_port_controller.sv
// Processor-side I/O peripheral: inbound FIFO feeding in_port with a rate-limited
// interrupt, and outbound FIFO capturing out_port writes for an external sink.
module io_port_controller
    import io_port_controller_pkg::*;
#(
    parameter int W         = W_DEFAULT,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int HOLDOFF   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [W-1:0]                ext_in_data,
    input  logic                        ext_in_valid,
    output logic                        ext_in_ready,
    output logic [W-1:0]                in_port,
    input  logic                        in_rd,
    input  logic                        irq_en,
    output logic                        interrupt,
    input  logic [W-1:0]                out_port,
    input  logic                        out_wr,
    output logic                        out_overflow,
    output logic [W-1:0]                ext_out_data,
    output logic                        ext_out_valid,
    input  logic                        ext_out_ready,
    output logic [clog2(IN_DEPTH):0]    in_count
);

    logic                       in_full;
    logic                       in_empty;
    logic                       out_full;
    logic                       out_empty;
    logic                       out_pop;
    logic [clog2(OUT_DEPTH):0]  out_count;
    logic                       unused_ok;

    irq_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       irq_q, irq_d;
    logic       ovf_q, ovf_d;

    assign ext_in_ready  = !in_full;
    assign ext_out_valid = !out_empty;
    assign out_pop       = ext_out_valid && ext_out_ready;
    assign interrupt     = irq_q;
    assign out_overflow  = ovf_q;
    assign unused_ok     = ^{out_count, in_empty};

    sync_fifo #(.W(W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ext_in_valid && ext_in_ready),
        .pop   (in_rd),
        .din   (ext_in_data),
        .dout  (in_port),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    sync_fifo #(.W(W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_wr),
        .pop   (out_pop),
        .din   (out_port),
        .dout  (ext_out_data),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    // The counter is loaded on entry to PULSE so that PULSE + HOLD + IDLE spans HOLDOFF+1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IRQ_IDLE: begin
                if (irq_en && (in_count != '0)) begin
                    state_d = IRQ_PULSE;
                    cnt_d   = 8'(HOLDOFF);
                end
            end
            IRQ_PULSE: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_d == 8'd0) ? IRQ_IDLE : IRQ_HOLD;
            end
            IRQ_HOLD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_d == 8'd0) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        irq_d = (state_d == IRQ_PULSE);
        ovf_d = ovf_q || (out_wr && out_full && !out_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IRQ_IDLE;
            cnt_q   <= 8'd0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: reset, interrupt timing, inbound
// back-pressure, outbound overflow, full-with-pop write and mid-operation reset.
module tb_io_port_controller;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] ext_in_data;
    logic         ext_in_valid;
    logic         ext_in_ready;
    logic [W-1:0] in_port;
    logic         in_rd;
    logic         irq_en;
    logic         interrupt;
    logic [W-1:0] out_port;
    logic         out_wr;
    logic         out_overflow;
    logic [W-1:0] ext_out_data;
    logic         ext_out_valid;
    logic         ext_out_ready;
    logic [2:0]   in_count;

    int n_vec = 0;
    int n_err = 0;
    int irq_seen;

    io_port_controller #(.W(W), .IN_DEPTH(4), .OUT_DEPTH(4), .HOLDOFF(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .in_port       (in_port),
        .in_rd         (in_rd),
        .irq_en        (irq_en),
        .interrupt     (interrupt),
        .out_port      (out_port),
        .out_wr        (out_wr),
        .out_overflow  (out_overflow),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_count      (in_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ext_in_data = '0; ext_in_valid = 1'b0; in_rd = 1'b0; irq_en = 1'b0;
        out_port = '0; out_wr = 1'b0; ext_out_ready = 1'b0;
        #1;
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        step(); step();
        rst = 1'b0;

        // Reset then idle
        irq_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (interrupt) irq_seen++;
        end
        chk("idle_irq_count", irq_seen, 0);
        chk("idle_in_port", 32'(in_port), 32'h0);
        chk("idle_in_count", 32'(in_count), 32'd0);
        chk("idle_in_ready", 32'(ext_in_ready), 32'd1);
        chk("idle_out_valid", 32'(ext_out_valid), 32'd0);
        chk("idle_out_data", 32'(ext_out_data), 32'h0);
        chk("idle_overflow", 32'(out_overflow), 32'd0);

        // Interrupt timing: push at N
        irq_en = 1'b1;
        ext_in_data = 16'h1234; ext_in_valid = 1'b1;
        step();                                   // N+1
        ext_in_valid = 1'b0;
        chk("irq_in_port_n1", 32'(in_port), 32'h1234);
        chk("irq_in_count_n1", 32'(in_count), 32'd1);
        chk("irq_low_n1", 32'(interrupt), 32'd0);
        step();                                   // N+2
        chk("irq_pulse_n2", 32'(interrupt), 32'd1);
        irq_seen = 0;
        for (int i = 0; i < 8; i++) begin         // N+3 .. N+10
            step();
            if (interrupt) irq_seen++;
        end
        chk("irq_holdoff_quiet", irq_seen, 0);
        step();                                   // N+11
        chk("irq_repeat_pulse", 32'(interrupt), 32'd1);
        in_rd = 1'b1;
        step();
        in_rd = 1'b0;
        chk("irq_after_rd_in_port", 32'(in_port), 32'h0);
        chk("irq_after_rd_count", 32'(in_count), 32'd0);
        irq_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (interrupt) irq_seen++;
        end
        chk("irq_stopped", irq_seen, 0);
        irq_en = 1'b0;

        // Read while empty is ignored
        in_rd = 1'b1;
        step();
        in_rd = 1'b0;
        chk("empty_rd_count", 32'(in_count), 32'd0);

        // Inbound back-pressure: 0xA0..0xA4 into a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            ext_in_data = 16'(16'hA0 + i);
            ext_in_valid = 1'b1;
            chk($sformatf("in_ready_before_push%0d", i), 32'(ext_in_ready), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) step();
        end
        chk("in_full_count", 32'(in_count), 32'd4);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("in_read%0d", j), 32'(in_port), 32'(16'hA0 + j));
            if (j == 1) chk("in_ready_after_pop", 32'(ext_in_ready), 32'd1);
            in_rd = 1'b1;
            step();
            in_rd = 1'b0;
            if (j == 1) begin
                ext_in_valid = 1'b0;
                chk("in_count_push_pop", 32'(in_count), 32'd3);
            end
        end
        chk("in_drained_count", 32'(in_count), 32'd0);
        chk("in_drained_port", 32'(in_port), 32'h0);

        // Outbound overflow
        ext_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            out_port = 16'(i);
            out_wr = 1'b1;
            step();
            if (i == 4) chk("ovf_not_yet", 32'(out_overflow), 32'd0);
        end
        out_wr = 1'b0;
        chk("ovf_set", 32'(out_overflow), 32'd1);
        chk("ovf_valid", 32'(ext_out_valid), 32'd1);
        step();
        chk("ovf_data_stable", 32'(ext_out_data), 32'h0001);
        ext_out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ovf_drain%0d", j), 32'(ext_out_data), 32'(j + 1));
            step();
        end
        ext_out_ready = 1'b0;
        chk("ovf_drained_valid", 32'(ext_out_valid), 32'd0);
        chk("ovf_drained_data", 32'(ext_out_data), 32'h0);
        chk("ovf_sticky", 32'(out_overflow), 32'd1);

        // Full outbound FIFO with simultaneous write and pop
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_clears_ovf", 32'(out_overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            out_port = 16'(16'h11 + i);
            out_wr = 1'b1;
            step();
        end
        out_port = 16'hBEEF; out_wr = 1'b1; ext_out_ready = 1'b1;
        chk("full_pop_head", 32'(ext_out_data), 32'h0011);
        step();
        out_wr = 1'b0;
        chk("full_pop_no_ovf", 32'(out_overflow), 32'd0);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("full_pop_drain%0d", j), 32'(ext_out_data), (j < 3) ? 32'(16'h12 + j) : 32'hBEEF);
            step();
        end
        ext_out_ready = 1'b0;
        chk("full_pop_empty", 32'(ext_out_valid), 32'd0);

        // Mid-HOLD reset with two entries in each FIFO
        irq_en = 1'b1;
        ext_in_data = 16'h51; ext_in_valid = 1'b1;
        out_port = 16'h61; out_wr = 1'b1;
        step();                                   // M+1
        ext_in_data = 16'h52; out_port = 16'h62;
        chk("mid_no_irq_m1", 32'(interrupt), 32'd0);
        step();                                   // M+2
        ext_in_valid = 1'b0; out_wr = 1'b0;
        chk("mid_pulse_m2", 32'(interrupt), 32'd1);
        chk("mid_in_count", 32'(in_count), 32'd2);
        step();                                   // M+3, in HOLD
        chk("mid_hold_low", 32'(interrupt), 32'd0);
        chk("mid_out_valid", 32'(ext_out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_count", 32'(in_count), 32'd0);
        chk("mid_rst_out_valid", 32'(ext_out_valid), 32'd0);
        chk("mid_rst_interrupt", 32'(interrupt), 32'd0);
        chk("mid_rst_in_port", 32'(in_port), 32'h0);
        step();
        rst = 1'b0;
        irq_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (interrupt) irq_seen++;
        end
        chk("post_rst_no_irq", irq_seen, 0);
        ext_in_data = 16'h77; ext_in_valid = 1'b1;
        step();
        ext_in_valid = 1'b0;
        chk("post_rst_no_irq_k1", 32'(interrupt), 32'd0);
        step();
        chk("post_rst_pulse_k2", 32'(interrupt), 32'd1);
        chk("post_rst_in_port", 32'(in_port), 32'h0077);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
